// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and width helper for the reverse double-dabble BCD-to-binary converter.
package bcd_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGIT  = 9;
  localparam int ADJ_THRESH = 8;
  localparam int ADJ_SUB    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest width that holds 10**digits - 1; this is also the shift count.
  function automatic int bin_width(input int digits);
    case (digits)
      1:       return 4;
      2:       return 7;
      3:       return 10;
      default: return 14;
    endcase
  endfunction

endpackage

// File: rtl/bcd2binary_reverse_dabble_if.sv
// Converter bus: packed BCD word in with valid/ready, binary result out with valid/ready, plus status.
interface bcd2binary_reverse_dabble_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = bin_width(DIGITS)
);

  logic                       in_valid;
  logic                       in_ready;
  logic [DIGIT_W*DIGITS-1:0]  bcd_in;
  logic                       out_valid;
  logic                       out_ready;
  logic [BIN_W-1:0]           binary_out;
  logic                       bcd_err;
  logic                       busy;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, binary_out, bcd_err, busy
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, binary_out, bcd_err, busy
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// Per-nibble reverse-dabble correction: nibble-3 when nibble>=8, else pass-through; purely combinational.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  output logic [DIGIT_W-1:0] adjusted
);

  always_comb begin
    if (nibble >= DIGIT_W'(ADJ_THRESH)) begin
      adjusted = nibble - DIGIT_W'(ADJ_SUB);
    end else begin
      adjusted = nibble;
    end
  end

endmodule

// File: rtl/bcd2binary_reverse_dabble.sv
// Packed BCD to binary by reverse double dabble: result BIN_W edges after acceptance (error: on acceptance edge).
// One word in flight; in_ready only in IDLE, result held in DONE until out_ready.
module bcd2binary_reverse_dabble
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  bcd2binary_reverse_dabble_if.slave   bus
);

  localparam int BIN_W = bin_width(DIGITS);
  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state;
  state_t             state_nxt;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   shifted;
  logic [SCR_W-1:0]   stepped;
  logic [CNT_W-1:0]   count;
  logic               err_q;
  logic               in_ready_int;
  logic               out_valid_int;
  logic               accept;
  logic               has_bad;
  logic               last_iter;

  assign accept    = bus.in_valid && in_ready_int;
  assign last_iter = (count == CNT_W'(BIN_W - 1));
  assign shifted   = scratch >> 1;

  always_comb begin
    has_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bus.bcd_in[k*DIGIT_W +: DIGIT_W] > DIGIT_W'(MAX_DIGIT)) begin
        has_bad = 1'b1;
      end
    end
  end

  // Binary bits below the BCD field only shift; every BCD nibble gets its own corrector.
  assign stepped[BIN_W-1:0] = shifted[BIN_W-1:0];

  for (genvar k = 0; k < DIGITS; k++) begin : gen_adj
    bcd_digit_adjust u_adj (
      .nibble   (shifted[BIN_W + k*DIGIT_W +: DIGIT_W]),
      .adjusted (stepped[BIN_W + k*DIGIT_W +: DIGIT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = has_bad ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_int  = (state == IDLE);
    out_valid_int = (state == DONE);
    bus.in_ready  = in_ready_int;
    bus.out_valid = out_valid_int;
    bus.busy      = (state != IDLE);
  end

  // On the error path the low field stays cleared, so the reported result is zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      scratch <= '0;
      count   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            scratch <= {bus.bcd_in, BIN_W'(0)};
            count   <= '0;
            err_q   <= has_bad;
          end
        end
        SHIFT: begin
          scratch <= stepped;
          count   <= count + CNT_W'(1);
        end
        default: begin
          scratch <= scratch;
        end
      endcase
    end
  end

  assign bus.binary_out = scratch[BIN_W-1:0];
  assign bus.bcd_err    = err_q;

endmodule
